// File: rtl/matmul_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : matmul_sequencer_if
//  Brief    : Command handshake and dispatcher control bundle for the
//             matmul sequencer. The sequencer uses the slave side; the
//             command front end and dispatcher/array pair use the master side.
//  Revision : 1.0 - initial release
// ============================================================================
interface matmul_sequencer_if #(
    parameter int CNT_W = 6,
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic             req_accumulate;
    logic [TAG_W-1:0] req_tag;
    logic             dis_load;
    logic [CNT_W-1:0] dis_count;
    logic             dis_should_add;
    logic             dis_stall;
    logic             busy;
    logic             done;
    logic [TAG_W-1:0] done_tag;

    modport master (
        output req_valid, req_accumulate, req_tag, dis_stall,
        input  req_ready, dis_load, dis_count, dis_should_add, busy, done, done_tag
    );

    modport slave (
        input  req_valid, req_accumulate, req_tag, dis_stall,
        output req_ready, dis_load, dis_count, dis_should_add, busy, done, done_tag
    );
endinterface
`default_nettype wire

// File: rtl/matmul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : matmul_sequencer
//  Brief    : Single-job controller for the 4x4 skewed-feed dispatcher. Takes
//             one job per handshake, strobes the operand load, steps the
//             dispatcher through the feed-plus-drain window, then reports
//             completion with the job tag.
//  Options  : MATSEQ_PERF_EN - adds perf_jobs / perf_stalls counters.
//  Revision : 1.0 - initial release
// ============================================================================
module matmul_sequencer #(
    parameter int DIM   = 4,
    parameter int DRAIN = 4,
    parameter int CNT_W = 6,
    parameter int TAG_W = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    matmul_sequencer_if.slave bus
`ifdef MATSEQ_PERF_EN
    ,
    output logic [15:0]       perf_jobs,
    output logic [15:0]       perf_stalls
`endif
);

    // Final step index: feed window of 2*DIM-1 counts plus the drain steps.
    localparam int             c_LAST_INT = 2*DIM - 2 + DRAIN;
    localparam logic [CNT_W-1:0] c_LAST   = CNT_W'(c_LAST_INT);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_LOAD   = 2'd1;
    localparam logic [1:0] c_STREAM = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    generate
        if ((2**CNT_W) < (2*DIM - 1 + DRAIN)) begin : g_cnt_w_check
            $error("matmul_sequencer: CNT_W too narrow for the feed-plus-drain window");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic             r_acc;
    logic [TAG_W-1:0] r_tag;
    logic             w_accept;

    assign w_accept = (r_state == c_IDLE) && bus.req_valid;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; stall only matters while streaming.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (bus.req_valid) w_state_nxt = c_LOAD;
            c_LOAD:   w_state_nxt = c_STREAM;
            c_STREAM: if (!bus.dis_stall && (r_count == c_LAST)) w_state_nxt = c_DONE;
            c_DONE:   w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    // Step counter: advances on unstalled STREAM cycles, zero elsewhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (r_state == c_STREAM) begin
            if (!bus.dis_stall) begin
                r_count <= (r_count == c_LAST) ? '0 : r_count + CNT_W'(1);
            end
        end else begin
            r_count <= '0;
        end
    end

    // Job attributes captured at accept so later input changes cannot leak in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= 1'b0;
            r_tag <= '0;
        end else if (w_accept) begin
            r_acc <= bus.req_accumulate;
            r_tag <= bus.req_tag;
        end
    end

    // Output decode; every output depends only on flops, never on inputs.
    always_comb begin
        bus.req_ready      = 1'b0;
        bus.dis_load       = 1'b0;
        bus.dis_count      = r_count;
        bus.dis_should_add = 1'b0;
        bus.busy           = 1'b0;
        bus.done           = 1'b0;
        bus.done_tag       = '0;
        case (r_state)
            c_IDLE: begin
                bus.req_ready = 1'b1;
            end
            c_LOAD: begin
                bus.dis_load = 1'b1;
                bus.busy     = 1'b1;
            end
            c_STREAM: begin
                bus.busy           = 1'b1;
                bus.dis_should_add = r_acc;
            end
            c_DONE: begin
                bus.done     = 1'b1;
                bus.done_tag = r_tag;
            end
            default: begin
                bus.req_ready = 1'b0;
            end
        endcase
    end

`ifdef MATSEQ_PERF_EN
    logic [15:0] r_perf_jobs;
    logic [15:0] r_perf_stalls;

    // Completed-job counter wraps; stall counter saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_jobs   <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (r_state == c_DONE) begin
                r_perf_jobs <= r_perf_jobs + 16'd1;
            end
            if ((r_state == c_STREAM) && bus.dis_stall && (r_perf_stalls != 16'hFFFF)) begin
                r_perf_stalls <= r_perf_stalls + 16'd1;
            end
        end
    end

    assign perf_jobs   = r_perf_jobs;
    assign perf_stalls = r_perf_stalls;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matmul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matmul_sequencer
//  Brief    : Self-checking bench for matmul_sequencer. A job-position model
//             predicts every output each cycle; directed scenarios are
//             followed by a randomized run with occasional async resets.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_matmul_sequencer;

    localparam int DIM   = 4;
    localparam int DRAIN = 4;
    localparam int CNT_W = 6;
    localparam int TAG_W = 4;
    localparam int LAST  = 2*DIM - 2 + DRAIN;

    logic clk;
    logic rst;

    matmul_sequencer_if #(.CNT_W(CNT_W), .TAG_W(TAG_W)) bus ();

`ifdef MATSEQ_PERF_EN
    logic [15:0] perf_jobs;
    logic [15:0] perf_stalls;
`endif

    matmul_sequencer #(
        .DIM   (DIM),
        .DRAIN (DRAIN),
        .CNT_W (CNT_W),
        .TAG_W (TAG_W)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus)
`ifdef MATSEQ_PERF_EN
        ,
        .perf_jobs   (perf_jobs),
        .perf_stalls (perf_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: m_pos is the job's position in its life (-1 idle, 0 load,
    // 1..LAST+1 stream with count m_pos-1, LAST+2 done).
    int         m_pos    = -1;
    logic       m_acc    = 1'b0;
    logic [3:0] m_tag    = '0;
    int         m_jobs   = 0;
    int         m_stalls = 0;
    int         cyc      = 0;
    int         done_cyc[$];

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, obs, exp);
        end
    endtask

    function automatic bit in_stream();
        return (m_pos >= 1) && (m_pos <= LAST + 1);
    endfunction

    task automatic model_reset();
        m_pos    = -1;
        m_jobs   = 0;
        m_stalls = 0;
    endtask

    task automatic model_edge(input logic v, input logic a, input logic [3:0] t, input logic s);
        if (rst) begin
            model_reset();
        end else if (m_pos < 0) begin
            if (v) begin
                m_pos = 0;
                m_acc = a;
                m_tag = t;
            end
        end else if (in_stream() && s) begin
            m_stalls++;
        end else if (m_pos == LAST + 2) begin
            m_pos = -1;
            m_jobs++;
        end else begin
            m_pos++;
        end
    endtask

    task automatic check_outputs();
        logic       e_ready, e_busy, e_load, e_add, e_done;
        int         e_cnt;
        logic [3:0] e_tag;
        e_ready = 1'b1; e_busy = 1'b0; e_load = 1'b0; e_add = 1'b0; e_done = 1'b0;
        e_cnt   = 0;    e_tag  = '0;
        if (m_pos == 0) begin
            e_ready = 1'b0; e_busy = 1'b1; e_load = 1'b1;
        end else if (in_stream()) begin
            e_ready = 1'b0; e_busy = 1'b1; e_cnt = m_pos - 1; e_add = m_acc;
        end else if (m_pos == LAST + 2) begin
            e_ready = 1'b0; e_done = 1'b1; e_tag = m_tag;
        end
        check("req_ready",      32'(bus.req_ready),      32'(e_ready));
        check("busy",           32'(bus.busy),           32'(e_busy));
        check("dis_load",       32'(bus.dis_load),       32'(e_load));
        check("dis_count",      32'(bus.dis_count),      32'(e_cnt));
        check("dis_should_add", 32'(bus.dis_should_add), 32'(e_add));
        check("done",           32'(bus.done),           32'(e_done));
        check("done_tag",       32'(bus.done_tag),       32'(e_tag));
`ifdef MATSEQ_PERF_EN
        check("perf_jobs",      32'(perf_jobs),          32'(m_jobs & 16'hFFFF));
        check("perf_stalls",    32'(perf_stalls),        32'((m_stalls > 16'hFFFF) ? 16'hFFFF : m_stalls));
`endif
        if (bus.done === 1'b1) done_cyc.push_back(cyc);
    endtask

    // Drive inputs for the next edge, update the model at that edge and
    // check all outputs half a cycle later.
    task automatic step(input logic v, input logic a, input logic [3:0] t, input logic s);
        bus.req_valid      = v;
        bus.req_accumulate = a;
        bus.req_tag        = t;
        bus.dis_stall      = s;
        @(posedge clk);
        model_edge(v, a, t, s);
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any edge.
    task automatic async_reset_pulse();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        #3;
        step(1'b0, 1'b0, 4'h0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin : main
        int a_cyc;
        int nst;
        int guard;
        rst                = 1'b1;
        bus.req_valid      = 1'b0;
        bus.req_accumulate = 1'b0;
        bus.req_tag        = '0;
        bus.dis_stall      = 1'b0;
        @(negedge clk);
        check_outputs();
        step(1'b0, 1'b0, 4'h0, 1'b0);
        rst = 1'b0;

        // Reset then idle.
        idle_steps(5);

        // Single plain job, tag 0x3.
        done_cyc.delete();
        step(1'b1, 1'b0, 4'h3, 1'b0);
        a_cyc = cyc;
        idle_steps(14);
        check("single_done_count", 32'(done_cyc.size()), 32'd1);
        if (done_cyc.size() > 0) check("single_latency", 32'(done_cyc[0] - a_cyc), 32'd12);

        // Accumulate job, three stall cycles while the count sits at 4.
        done_cyc.delete();
        step(1'b1, 1'b1, 4'hA, 1'b0);
        a_cyc = cyc;
        nst   = 0;
        for (int i = 0; i < 18; i++) begin
            logic s;
            s = in_stream() && (m_pos - 1 == 4) && (nst < 3);
            if (s) nst++;
            step(1'b0, $urandom_range(0, 1) == 1, 4'($urandom), s);
        end
        check("stall_done_count", 32'(done_cyc.size()), 32'd1);
        if (done_cyc.size() > 0) check("stall_latency", 32'(done_cyc[0] - a_cyc), 32'd15);

        // Back-to-back with valid held high.
        done_cyc.delete();
        step(1'b1, 1'b0, 4'h1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 4'h2, 1'b0);
        idle_steps(20);
        check("b2b_done_count", 32'(done_cyc.size()), 32'd2);
        if (done_cyc.size() >= 2) check("b2b_spacing", 32'(done_cyc[1] - done_cyc[0]), 32'(LAST + 4));

        // Reset while the count is 6, then a fresh job with tag 0x5.
        done_cyc.delete();
        step(1'b1, 1'b0, 4'h7, 1'b0);
        guard = 0;
        while (!(in_stream() && (m_pos - 1 == 6)) && guard < 20) begin
            step(1'b0, 1'b0, 4'h0, 1'b0);
            guard++;
        end
        check("midstream_reach", 32'(guard < 20), 32'd1);
        async_reset_pulse();
        step(1'b1, 1'b0, 4'h5, 1'b0);
        check("post_reset_accept", 32'(bus.dis_load), 32'd1);
        idle_steps(14);
        check("post_reset_dones", 32'(done_cyc.size()), 32'd1);

        // Randomized traffic with occasional async resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset_pulse();
            end else begin
                step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                     4'($urandom), $urandom_range(0, 3) == 0);
            end
        end
        idle_steps(LAST + 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Single-job controller for the 4x4 skewed-feed dispatcher in front of the systolic matrix unit.
- Accepts one matrix job per valid/ready handshake and strobes the dispatcher's operand registers to load.
- Drives the dispatcher's count and should-add inputs through the full feed-plus-drain window, then reports completion with the job tag.
- Sits between the command front end and the dispatcher/array pair.

Parameters:
- DIM, 4: matrix edge length; the feed window is 2*DIM-1 counts.
- DRAIN, 4: extra count steps after the last feed, to let the array empty.
- CNT_W, 6: width of dis_count. Elaboration error if 2^CNT_W < 2*DIM-1+DRAIN.
- TAG_W, 4: width of the job tag.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous active-high reset.
- req_valid, input, 1: job request valid.
- req_ready, output, 1: sequencer can accept a job.
- req_accumulate, input, 1: job adds into existing results; sampled at accept.
- req_tag, input, TAG_W: job identifier; sampled at accept.
- dis_load, output, 1: one-cycle strobe to latch the r/a operand matrices into the dispatcher.
- dis_count, output, CNT_W: dispatcher step index.
- dis_should_add, output, 1: dispatcher accumulate select.
- dis_stall, input, 1: downstream hold request; freezes stepping.
- busy, output, 1: a job is in flight.
- done, output, 1: one-cycle completion pulse.
- done_tag, output, TAG_W: tag of the completed job; valid while done=1.

Behaviour:
- Constant LAST = 2*DIM-2+DRAIN; defaults give LAST = 10.
- Reset (async assert, any state): state=IDLE, req_ready=1, dis_load=0, dis_count=0, dis_should_add=0, busy=0, done=0, done_tag=0.
- IDLE: req_ready=1, busy=0.
  - On req_valid&&req_ready at an edge: latch req_accumulate and req_tag, go to LOAD.
  - Without req_valid: stay in IDLE; dis_count stays 0.
- LOAD (exactly 1 cycle): dis_load=1, dis_count=0, busy=1, req_ready=0. Go to STREAM. dis_stall is ignored in LOAD.
- STREAM: busy=1.
  - dis_should_add = latched accumulate, held constant for the whole state.
  - dis_count starts at 0.
  - Each edge with dis_stall=0: dis_count increments by 1.
  - Edge with dis_stall=1: dis_count holds.
  - When dis_count==LAST and dis_stall=0: go to DONE.
  - dis_count never exceeds LAST and never wraps.
- DONE (exactly 1 cycle): done=1, done_tag = latched tag, busy=0, req_ready=0, dis_should_add=0, dis_count=0. Go to IDLE.
- dis_should_add is 0 in every state other than STREAM.
- Unstalled latency: accept at edge T; LOAD during T..T+1; STREAM spans LAST+1 cycles; done=1 in the cycle after edge T+LAST+2. Defaults: 11 STREAM cycles, done 12 cycles after the accept edge.
- Back-to-back jobs: a request held through DONE is accepted on the first IDLE cycle. Minimum job spacing is LAST+4 cycles.
- req_valid deasserted while busy: no effect. The latched tag and accumulate bit are immune to input changes after accept.
- Reset during STREAM: the job is aborted silently with no done pulse. After reset release, the sequencer is ready the next cycle.
- All outputs are registered; no combinational input-to-output paths.

Optional Feature:
- Macro: MATSEQ_PERF_EN.
- Defined:
  - Adds output perf_jobs[15:0]: completed jobs; increments on each done pulse, wraps at 0xFFFF→0.
  - Adds output perf_stalls[15:0]: STREAM cycles with dis_stall=1; saturates at 0xFFFF.
  - Both counters clear on rst.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset then idle: rst pulse, req_valid=0 for 5 cycles → req_ready=1, busy=0, dis_count=0, done=0 throughout.
- Single job: req_tag=0x3, req_accumulate=0 accepted → dis_load for 1 cycle; dis_count 0,1,…,10 on consecutive cycles with dis_should_add=0; done=1 with done_tag=0x3 12 cycles after accept; then req_ready=1.
- Accumulate job with stall: req_tag=0xA, req_accumulate=1; dis_stall=1 for 3 cycles while dis_count==4 → count holds at 4 for those cycles; dis_should_add=1 across all of STREAM; done arrives 3 cycles later than unstalled (15 cycles after accept).
- Back-to-back: req_valid held high with tags 0x1 then 0x2 → two done pulses spaced exactly LAST+4=14 cycles apart, tags 0x1 then 0x2; req_ready=0 during LOAD, STREAM and DONE.
- Reset mid-stream: assert rst when dis_count==6 → outputs go to reset values immediately with no done pulse; a new job (tag 0x5) after release completes normally with done_tag=0x5.
- With MATSEQ_PERF_EN defined: run 3 jobs with 2 total stall cycles → perf_jobs=3, perf_stalls=2.
